// File: rtl/tick_divider_pkg.sv
// Shared constants for the multi-channel tick generator.
package tick_divider_pkg;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    localparam int unsigned DEFAULT_WIDTH = 32'd32;

endpackage

// File: rtl/tick_divider_ch.sv
// One tick channel: counts enabled cycles against a loadable period and
// emits a registered tick, a toggling level and a one-shot done flag.
module tick_divider_ch
    import tick_divider_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned RESET_DIV = 32'd50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic             load,
    input  logic [WIDTH-1:0] div_in,
    input  logic             mode,
    output logic             tick,
    output logic             level,
    output logic             done
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             level_q, level_d;
    logic             done_q, done_d;
    logic             terminal_s;

    // Greater-or-equal so a period shrunk below the running count fires at once.
    assign terminal_s = (cnt_q >= div_q);

    // Next-state logic: restart beats everything, load is independent.
    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        level_d = level_q;
        done_d  = done_q;

        if (load) begin
            div_d = div_in;
        end else begin
            div_d = div_q;
        end

        if (restart) begin
            cnt_d   = {WIDTH{1'b0}};
            level_d = 1'b0;
            done_d  = 1'b0;
        end else if (!en) begin
            cnt_d = cnt_q;
        end else if ((mode == MODE_ONESHOT) && done_q) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (terminal_s) begin
            cnt_d   = {WIDTH{1'b0}};
            tick_d  = 1'b1;
            level_d = ~level_q;
            if (mode == MODE_ONESHOT) begin
                done_d = 1'b1;
            end else begin
                done_d = done_q;
            end
        end else begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= {WIDTH{1'b0}};
            div_q   <= WIDTH'(RESET_DIV);
            tick_q  <= 1'b0;
            level_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            level_q <= level_d;
            done_q  <= done_d;
        end
    end

    assign tick  = tick_q;
    assign level = level_q;
    assign done  = done_q;

endmodule

// File: rtl/tick_divider.sv
// Multi-channel programmable tick generator; one independent channel per lane.
module tick_divider
    import tick_divider_pkg::*;
#(
    parameter int unsigned NCH       = 32'd4,
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned RESET_DIV = 32'd50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       restart,
    input  logic [NCH-1:0]       load,
    input  logic [NCH*WIDTH-1:0] div_in,
    input  logic [NCH-1:0]       mode,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       level,
    output logic [NCH-1:0]       done
);

    for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
        tick_divider_ch #(
            .WIDTH     (WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .restart (restart[i]),
            .load    (load[i]),
            .div_in  (div_in[i*WIDTH +: WIDTH]),
            .mode    (mode[i]),
            .tick    (tick[i]),
            .level   (level[i]),
            .done    (done[i])
        );
    end

endmodule
